// File: rtl/xy_motion_sched.sv
// X/Y stepper step-pulse scheduler: manual-jog vs CPU arbitration, timed pulses, position counts.
// Optional soft position limits via `define XY_SOFT_LIMIT_EN (adds x_limit / y_limit ports).

module xy_motion_axis #(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned PULSE_W    = 500,
  parameter int unsigned DIR_SETUP  = 1000,
  parameter int unsigned MIN_PERIOD = 2000,
  parameter int unsigned JOG_PERIOD = 200000,
  parameter int unsigned POS_W      = 16,
  parameter logic        POS_DIR    = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             req_dir_i,
  input  logic             req_manual_i,
  input  logic [31:0]      speed_i,
`ifdef XY_SOFT_LIMIT_EN
  input  logic [POS_W-1:0] limit_i,
`endif
  output logic             step_o,
  output logic             dir_o,
  output logic [POS_W-1:0] pos_o,
  output logic             active_o,
  output logic             take_o,
  output logic             take_manual_o
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE_HI, PULSE_LO} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0] LO_SUB   = CNT_W'(PULSE_W + 1);
  localparam logic [CNT_W-1:0] JOG_LD   = CNT_W'(JOG_PERIOD);
  localparam logic [CNT_W-1:0] MIN_LD   = CNT_W'(MIN_PERIOD);
  localparam logic [31:0]      MIN_32   = 32'(MIN_PERIOD);
  localparam logic [31:0]      MAX_32   = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, period_q, period_d, period_req;
  logic               dir_q, dir_d, step_q, go_hi, req_ok;
  logic [POS_W-1:0]   pos_q, pos_d;

  always_comb begin
    if (req_manual_i)          period_req = JOG_LD;
    else if (speed_i < MIN_32) period_req = MIN_LD;
    else if (speed_i > MAX_32) period_req = '1;
    else                       period_req = CNT_W'(speed_i);
  end

`ifdef XY_SOFT_LIMIT_EN
  // Position is signed, limit unsigned: compare in a widened signed domain.
  localparam logic signed [POS_W+1:0] ONE_S = (POS_W+2)'(1);
  logic signed [POS_W+1:0] pos_ext, next_pos, lim_ext;
  always_comb begin
    pos_ext  = signed'({{2{pos_q[POS_W-1]}}, pos_q});
    lim_ext  = signed'({2'b00, limit_i});
    next_pos = (req_dir_i == POS_DIR) ? pos_ext + ONE_S : pos_ext - ONE_S;
    req_ok   = req_i && !next_pos[POS_W+1] && (next_pos <= lim_ext);
  end
`else
  assign req_ok = req_i;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    period_d      = period_q;
    dir_d         = dir_q;
    pos_d         = pos_q;
    go_hi         = 1'b0;
    take_o        = 1'b0;
    take_manual_o = 1'b0;
    unique case (state_q)
      SETUP: begin
        if (cnt_q == '0) go_hi = 1'b1;
        else             cnt_d = cnt_q - CNT_ONE;
      end
      PULSE_HI: begin
        if (cnt_q == '0) begin
          state_d = PULSE_LO;
          cnt_d   = period_q - LO_SUB;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        // IDLE, or PULSE_LO: arbitration only on its last cycle
        if (state_q == PULSE_LO && cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (req_ok) begin
          take_o        = 1'b1;
          take_manual_o = req_manual_i;
          if (req_dir_i == dir_q) begin
            go_hi = 1'b1;
          end else begin
            state_d = SETUP;
            dir_d   = req_dir_i;
            cnt_d   = SETUP_LD;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    if (go_hi) begin
      state_d  = PULSE_HI;
      cnt_d    = PULSE_LD;
      period_d = period_req;
      pos_d    = (dir_d == POS_DIR) ? pos_q + POS_ONE : pos_q - POS_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      dir_q    <= 1'b0;
      pos_q    <= '0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
      step_q   <= (state_d == PULSE_HI);
    end
  end

  assign step_o   = step_q;
  assign dir_o    = dir_q;
  assign pos_o    = pos_q;
  assign active_o = (state_d != IDLE);

endmodule

module xy_motion_sched #(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned PULSE_W    = 500,
  parameter int unsigned DIR_SETUP  = 1000,
  parameter int unsigned MIN_PERIOD = 2000,
  parameter int unsigned JOG_PERIOD = 200000,
  parameter int unsigned POS_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             manual_en,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic [31:0]      cpu_x_speed,
  input  logic [31:0]      cpu_x_dir,
  input  logic [31:0]      cpu_y_speed,
  input  logic [31:0]      cpu_y_dir,
`ifdef XY_SOFT_LIMIT_EN
  input  logic [POS_W-1:0] x_limit,
  input  logic [POS_W-1:0] y_limit,
`endif
  output logic             x_step,
  output logic             x_dir,
  output logic             y_step,
  output logic             y_dir,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic             busy,
  output logic             src_manual
);

  logic x_man, y_man, x_req, y_req, x_req_dir, y_req_dir;
  logic x_active, y_active, x_take, y_take, x_take_man, y_take_man;
  logic busy_q, src_manual_q;
  logic unused_dir_bits;

  // Both buttons of one axis pressed cancels the manual request on that axis.
  assign x_man     = manual_en && (btn_left ^ btn_right);
  assign y_man     = manual_en && (btn_up ^ btn_down);
  assign x_req     = x_man || (cpu_x_speed != '0);
  assign y_req     = y_man || (cpu_y_speed != '0);
  assign x_req_dir = x_man ? btn_left : cpu_x_dir[0];
  assign y_req_dir = y_man ? btn_up   : cpu_y_dir[0];
  assign unused_dir_bits = ^{cpu_x_dir[31:1], cpu_y_dir[31:1]};

  xy_motion_axis #(
    .CNT_W(CNT_W), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP), .MIN_PERIOD(MIN_PERIOD),
    .JOG_PERIOD(JOG_PERIOD), .POS_W(POS_W), .POS_DIR(1'b0)
  ) u_x (
    .clk_i(clock), .rst_ni(reset), .req_i(x_req), .req_dir_i(x_req_dir),
    .req_manual_i(x_man), .speed_i(cpu_x_speed),
`ifdef XY_SOFT_LIMIT_EN
    .limit_i(x_limit),
`endif
    .step_o(x_step), .dir_o(x_dir), .pos_o(x_pos), .active_o(x_active),
    .take_o(x_take), .take_manual_o(x_take_man)
  );

  xy_motion_axis #(
    .CNT_W(CNT_W), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP), .MIN_PERIOD(MIN_PERIOD),
    .JOG_PERIOD(JOG_PERIOD), .POS_W(POS_W), .POS_DIR(1'b1)
  ) u_y (
    .clk_i(clock), .rst_ni(reset), .req_i(y_req), .req_dir_i(y_req_dir),
    .req_manual_i(y_man), .speed_i(cpu_y_speed),
`ifdef XY_SOFT_LIMIT_EN
    .limit_i(y_limit),
`endif
    .step_o(y_step), .dir_o(y_dir), .pos_o(y_pos), .active_o(y_active),
    .take_o(y_take), .take_manual_o(y_take_man)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q       <= 1'b0;
      src_manual_q <= 1'b0;
    end else begin
      busy_q <= x_active || y_active;
      if (x_take || y_take)
        src_manual_q <= (x_take && x_take_man) || (y_take && y_take_man);
    end
  end

  assign busy       = busy_q;
  assign src_manual = src_manual_q;

endmodule

// File: doc/xy_motion_sched.md
Name: xy_motion_sched

Overview:
- Per-axis step-pulse scheduler and source arbiter for the X/Y stepper drivers.
- Arbitrates between manual button jog and processor-commanded motion, which arrives through the memory-mapped speed/direction registers (xSpeed, xDirection, ySpeed, yDirection).
- Converts each winning request into timed step pulses with guaranteed pulse width and direction-setup dwell.
- Keeps a signed step-position count per axis.

Parameters:
- CNT_W, 24, width of the period/dwell counters.
- PULSE_W, 500, step high time in clocks (≥1).
- DIR_SETUP, 1000, dwell in clocks after a direction change before the next step (≥1).
- MIN_PERIOD, 2000, minimum step period in clocks (must be ≥ PULSE_W+1).
- JOG_PERIOD, 200000, step period in clocks for manual jog.
- POS_W, 16, width of the position counters.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- manual_en, input, 1, 1 = button jog has priority over CPU commands.
- btn_left, input, 1, jog X negative.
- btn_right, input, 1, jog X positive.
- btn_up, input, 1, jog Y positive.
- btn_down, input, 1, jog Y negative.
- cpu_x_speed, input, 32, X step period in clocks; 0 = stop.
- cpu_x_dir, input, 32, X direction; 1 = negative, 0 = positive (only bit 0 is used).
- cpu_y_speed, input, 32, Y step period in clocks; 0 = stop.
- cpu_y_dir, input, 32, Y direction; 1 = positive, 0 = negative (only bit 0 is used).
- x_step, output, 1, X step pulse (registered).
- x_dir, output, 1, X direction pin (registered).
- y_step, output, 1, Y step pulse (registered).
- y_dir, output, 1, Y direction pin (registered).
- x_pos, output, POS_W, signed X step count.
- y_pos, output, POS_W, signed Y step count.
- busy, output, 1, either axis not in IDLE.
- src_manual, output, 1, the last arbitration decision selected manual jog.

Behaviour:
- Reset (reset=0, asynchronous): both axes go to IDLE. All outputs are 0: x_step, y_step, x_dir, y_dir, x_pos, y_pos, busy, src_manual.
- Request formation (combinational), per axis:
  - Manual request: manual_en=1 and exactly one of the axis's two buttons is pressed.
  - Both buttons of an axis pressed: no manual request on that axis.
  - CPU request: speed≠0.
  - Arbitration: manual request wins; otherwise CPU request; otherwise no request.
  - Requested direction for manual jog: btn_left → x_dir=1; btn_right → x_dir=0; btn_up → y_dir=1; btn_down → y_dir=0. For CPU requests, the requested direction is dir[0].
- Arbitration is sampled only in IDLE and on the last PULSE_LO cycle. A request or source change mid-pulse never truncates a pulse.
- Per-axis FSM: IDLE, SETUP, PULSE_HI, PULSE_LO.
  - IDLE, request with direction equal to the direction register: go to PULSE_HI, load count=PULSE_W-1, latch period.
  - IDLE, request with a different direction: go to SETUP, update the direction register, load count=DIR_SETUP-1.
  - SETUP: decrement the count. At count=0, go to PULSE_HI (load PULSE_W-1, latch period).
  - PULSE_HI: step output=1. At count=0, go to PULSE_LO with count=period-PULSE_W-1.
  - PULSE_LO: step output=0. At count=0, re-arbitrate exactly as from IDLE; with no request, go to IDLE.
- Step output is registered: high exactly PULSE_W cycles.
- Rising edges are exactly period clocks apart while the request and direction are held.
- Period latch rules:
  - Manual: JOG_PERIOD.
  - CPU: speed clamped to MIN_PERIOD if below it.
  - CPU: speed saturated to 2^CNT_W-1 if above it.
- A speed change takes effect at the next PULSE_HI entry.
- Position: updated on entry to PULSE_HI, ±1, wrapping modulo 2^POS_W.
  - X: +1 when x_dir=0, -1 when x_dir=1.
  - Y: +1 when y_dir=1, -1 when y_dir=0.
- A direction reversal always passes through SETUP. There are never zero-dwell reversals.
- Axes are independent; simultaneous X and Y activity is allowed.
- busy is registered: it is 1 in any cycle where either axis is outside IDLE.
- Reset asserted mid-pulse: the step output drops immediately (asynchronous). Position clears.

Optional Feature:
- Macro: XY_SOFT_LIMIT_EN.
- Defined: adds input ports x_limit and y_limit, each POS_W wide and unsigned.
  - A request whose step would move the position below 0 or above the limit is treated as no request.
  - If that axis is in PULSE_LO, it goes to IDLE.
  - Manual and CPU requests are treated alike.
- Not defined: the limit ports are absent and the position wraps freely.

Test Plan:
- Reset, then cpu_x_speed=2000, cpu_x_dir=0 → first x_step rises DIR_SETUP-independent (no dir change) 1 cycle after request. Pulses are 500 high, with 2000-cycle spacing. x_pos counts 1,2,3.
- While X is running positive, set cpu_x_dir=1 → current pulse completes. Then x_dir goes to 1 and 1000 cycles of SETUP follow before the next rise. x_pos decrements.
- cpu_y_speed=10 (below MIN_PERIOD) → y_step period measures 2000. Set speed=0 mid-PULSE_HI → the pulse stays 500 wide, then the axis goes to IDLE and busy=0.
- CPU X running, manual_en=1, btn_right held → src_manual=1 at the next PULSE_LO end, period 200000. btn_left+btn_right both held → no manual request, and the CPU command resumes.
- Assert reset during PULSE_HI with x_pos=5 → x_step=0, x_pos=0 and busy=0 in the same cycle.
- XY_SOFT_LIMIT_EN, x_limit=3, x_dir=0 → exactly 3 pulses, then IDLE. Reverse direction → stepping resumes.
